// File: rtl/branch_predictor.sv
// Fetch-stage predictor: bimodal 2-bit counter table for conditional branches plus a
// direct-mapped tagged BTB for JAL/JALR; registered prediction one cycle after lookup.
module branch_predictor #(
  parameter int BHT_ENTRIES = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_BITS    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_cond_branch,
  input  logic        if_uncond_branch,
  input  logic        if_jump,
  input  logic        if_link,
  input  logic [6:0]  if_branch_imm1,
  input  logic [4:0]  if_branch_imm2,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_cond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target
);
  localparam int BHT_W  = $clog2(BHT_ENTRIES);
  localparam int BTB_W  = $clog2(BTB_ENTRIES);
  localparam int TAG_LO = BTB_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

  logic [1:0]          bht        [BHT_ENTRIES];
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]         btb_target [BTB_ENTRIES];

  logic [BHT_W-1:0]    rd_bht_idx, wr_bht_idx;
  logic [BTB_W-1:0]    rd_btb_idx, wr_btb_idx;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic [31:0]         imm;
  logic                btb_hit;
  logic [1:0]          ctr_cur, ctr_next;
  logic                nxt_valid, nxt_taken;
  logic [31:0]         nxt_target;
  logic                unused_pc_bits;

  assign rd_bht_idx = if_pc[BHT_W+1:2];
  assign wr_bht_idx = upd_pc[BHT_W+1:2];
  assign rd_btb_idx = if_pc[BTB_W+1:2];
  assign wr_btb_idx = upd_pc[BTB_W+1:2];
  assign rd_tag     = if_pc[TAG_HI:TAG_LO];
  assign wr_tag     = upd_pc[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1], upd_pc[1:0], upd_pc[31:TAG_HI+1]};

  // B-type immediate reassembled from the pre-decode fields, sign-extended from bit 12
  assign imm = {{19{if_branch_imm1[6]}}, if_branch_imm1[6], if_branch_imm2[0],
                if_branch_imm1[5:0], if_branch_imm2[4:1], 1'b0};

  assign btb_hit = btb_valid[rd_btb_idx] && (btb_tag[rd_btb_idx] == rd_tag);

  always_comb begin
    nxt_valid  = 1'b0;
    nxt_taken  = 1'b0;
    nxt_target = 32'h0;
    if (if_valid) begin
      nxt_valid  = 1'b1;
      nxt_target = if_pc + 32'd4;
      if (if_cond_branch) begin
        if (bht[rd_bht_idx][1]) begin
          nxt_taken  = 1'b1;
          nxt_target = if_pc + imm;
        end
      end else if (if_jump || if_link || if_uncond_branch) begin
        if (btb_hit) begin
          nxt_taken  = 1'b1;
          nxt_target = btb_target[rd_btb_idx];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= 32'h0;
    end else begin
      pred_valid  <= nxt_valid;
      pred_taken  <= nxt_taken;
      pred_target <= nxt_target;
    end
  end

  assign ctr_cur = bht[wr_bht_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (upd_taken && ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    else if (!upd_taken && ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
  end

  // Table writes land at the edge, so same-cycle lookups read the old contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid && upd_cond) begin
      bht[wr_bht_idx] <= ctr_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[wr_btb_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit and need no reset
  always_ff @(posedge clock) begin
    if (upd_valid && upd_taken) begin
      btb_tag[wr_btb_idx]    <= wr_tag;
      btb_target[wr_btb_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;
  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid, if_cond_branch, if_uncond_branch, if_jump, if_link;
  logic [31:0] if_pc;
  logic [6:0]  if_branch_imm1;
  logic [4:0]  if_branch_imm2;
  logic        upd_valid, upd_cond, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;

  branch_predictor dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_cond_branch(if_cond_branch),
    .if_uncond_branch(if_uncond_branch), .if_jump(if_jump), .if_link(if_link),
    .if_branch_imm1(if_branch_imm1), .if_branch_imm2(if_branch_imm2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_cond(upd_cond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: counters as integers 0..3, BTB as parallel arrays indexed by (pc/4) mod N
  int          m_ctr [32];
  bit          m_bv  [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  logic        exp_valid, exp_taken;
  logic [31:0] exp_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_ctr[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
  endfunction

  function automatic void model_predict();
    int          imm;
    int unsigned bi, ti, tg;
    exp_valid = 1'b0; exp_taken = 1'b0; exp_target = 32'h0;
    if (!if_valid) return;
    exp_valid  = 1'b1;
    exp_target = if_pc + 32'd4;
    bi = (if_pc / 4) % 32;
    ti = (if_pc / 4) % 16;
    tg = (if_pc / 64) % 256;
    imm = (if_branch_imm1[6] ? -4096 : 0) + (if_branch_imm2[0] ? 2048 : 0)
        + int'(if_branch_imm1[5:0]) * 32 + int'(if_branch_imm2[4:1]) * 2;
    if (if_cond_branch) begin
      if (m_ctr[bi] >= 2) begin
        exp_taken  = 1'b1;
        exp_target = if_pc + 32'(imm);
      end
    end else if (if_jump || if_link || if_uncond_branch) begin
      if (m_bv[ti] && m_tag[ti] == tg) begin
        exp_taken  = 1'b1;
        exp_target = m_tgt[ti];
      end
    end
  endfunction

  function automatic void model_update();
    int unsigned bi, ti;
    if (!upd_valid) return;
    bi = (upd_pc / 4) % 32;
    ti = (upd_pc / 4) % 16;
    if (upd_cond) begin
      if (upd_taken && m_ctr[bi] < 3) m_ctr[bi]++;
      if (!upd_taken && m_ctr[bi] > 0) m_ctr[bi]--;
    end
    if (upd_taken) begin
      m_bv[ti]  = 1'b1;
      m_tag[ti] = (upd_pc / 64) % 256;
      m_tgt[ti] = upd_target;
    end
  endfunction

  task automatic step(input string tag);
    model_predict();
    @(posedge clock);
    #1;
    model_update();
    check({tag, "_valid"}, 32'(pred_valid), 32'(exp_valid));
    check({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
    check({tag, "_target"}, pred_target, exp_target);
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [3:0] fl,
                       input logic [6:0] i1, input logic [4:0] i2);
    if_valid = v; if_pc = pc;
    {if_cond_branch, if_uncond_branch, if_jump, if_link} = fl;
    if_branch_imm1 = i1; if_branch_imm2 = i2;
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic c,
                     input logic t, input logic [31:0] tgt);
    upd_valid = v; upd_pc = pc; upd_cond = c; upd_taken = t; upd_target = tgt;
  endtask

  localparam logic [3:0] F_COND = 4'b1000;
  localparam logic [3:0] F_JAL  = 4'b0110;
  localparam logic [3:0] F_ALL  = 4'b1111;

  initial begin
    reset = 1'b1;
    fetch(0, 0, 0, 0, 0);
    upd(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_valid", 32'(pred_valid), 32'h0);
    check("rst_target", pred_target, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    fetch(1, 32'h100, F_COND, 7'h7F, 5'h19);
    step("cond_init");
    check("cond_init_const", pred_target, 32'h104);

    fetch(0, 0, 0, 0, 0);
    upd(1, 32'h100, 1, 1, 32'hF8);
    step("upd1");
    upd(0, 0, 0, 0, 0);
    fetch(1, 32'h100, F_COND, 7'h7F, 5'h19);
    step("cond_trained");
    check("cond_trained_const", pred_target, 32'hF8);

    fetch(0, 0, 0, 0, 0);
    repeat (3) begin upd(1, 32'h100, 1, 1, 32'hF8); step("sat_hi"); end
    repeat (3) begin upd(1, 32'h100, 1, 0, 32'h0); step("dec"); end
    upd(0, 0, 0, 0, 0);
    fetch(1, 32'h100, F_COND, 7'h7F, 5'h19);
    step("cond_nt");
    check("cond_nt_const", 32'(pred_taken), 32'h0);
    upd(1, 32'h100, 1, 0, 32'h0);
    step("sat_lo");
    upd(1, 32'h100, 1, 1, 32'hF8);
    step("from_zero");
    upd(0, 0, 0, 0, 0);
    step("still_nt");

    fetch(1, 32'h200, F_JAL, 0, 0);
    step("jal_miss");
    fetch(0, 0, 0, 0, 0);
    upd(1, 32'h200, 0, 1, 32'h400);
    step("jal_upd");
    upd(0, 0, 0, 0, 0);
    fetch(1, 32'h200, F_JAL, 0, 0);
    step("jal_hit");
    check("jal_hit_const", pred_target, 32'h400);
    fetch(1, 32'h240, F_JAL, 0, 0);
    step("jal_alias");
    check("jal_alias_const", pred_target, 32'h244);

    // asynchronous reset in the middle of a cycle with trained tables
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(pred_valid), 32'h0);
    check("mid_rst_target", pred_target, 32'h0);
    model_reset();
    fetch(0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    fetch(1, 32'h200, F_JAL, 0, 0);
    step("post_rst_jal");
    check("post_rst_jal_const", 32'(pred_taken), 32'h0);
    fetch(1, 32'h100, F_COND, 7'h7F, 5'h19);
    step("post_rst_cond");

    fetch(1, 32'h300, F_COND, 7'h00, 5'h08);
    upd(1, 32'h300, 1, 1, 32'h310);
    step("rbw_same");
    check("rbw_same_const", 32'(pred_taken), 32'h0);
    upd(0, 0, 0, 0, 0);
    step("rbw_next");
    check("rbw_next_const", 32'(pred_taken), 32'h1);

    fetch(0, 32'hDEAD_BEEF, F_ALL, 7'h55, 5'h0A);
    step("invalid");

    fetch(0, 0, 0, 0, 0);
    upd(1, 32'h100, 1, 1, 32'h500);
    step("all_upd");
    upd(0, 0, 0, 0, 0);
    fetch(1, 32'h100, F_ALL, 7'h7F, 5'h19);
    step("all_flags");
    check("all_flags_const", pred_target, 32'hF8);

    for (int n = 0; n < 3000; n++) begin
      fetch(($urandom_range(0, 9) != 0), 32'($urandom_range(0, 511)) << 2,
            4'($urandom_range(0, 15)), 7'($urandom), 5'($urandom));
      upd(($urandom_range(0, 1) == 1), 32'($urandom_range(0, 511)) << 2,
          1'($urandom), 1'($urandom), $urandom);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor that consumes the per-instruction branch classification produced by pre-decode (conditional/unconditional, jump, link, and the raw B-type immediate fields). It returns a registered taken/target prediction to the fetch PC mux one cycle later. It is trained by branch resolutions arriving from the execute/retire side. It holds a bimodal table of 2-bit saturating counters (BHT) and a direct-mapped, tagged branch target buffer (BTB).

## Interface
- BHT_ENTRIES, 32, number of 2-bit counters (power of 2)
- BTB_ENTRIES, 16, number of BTB entries (power of 2)
- TAG_BITS, 8, BTB tag width
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch slot valid
- if_pc  in  32  PC of fetched instruction
- if_cond_branch  in  1  pre-decode: BEQ/BNE/BLT/BGE/BLTU/BGEU
- if_uncond_branch  in  1  pre-decode: JAL or JALR
- if_jump  in  1  pre-decode: JAL
- if_link  in  1  pre-decode: JALR
- if_branch_imm1  in  7  {imm[12], imm[10:5]}
- if_branch_imm2  in  5  {imm[4:1], imm[11]}
- upd_valid  in  1  resolution update valid
- upd_pc  in  32  PC of resolved branch
- upd_cond  in  1  resolved branch was conditional
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- pred_valid  out  1  prediction valid (registered)
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC

## Operation
- Indexing: BHT idx = pc[log2(BHT_ENTRIES)+1:2]; BTB idx = pc[log2(BTB_ENTRIES)+1:2]; tag = next TAG_BITS PC bits above the BTB idx.
- Immediate: imm = sign-extend 13 bits {imm1[6], imm2[0], imm1[5:0], imm2[4:1], 1'b0} to 32; branch target = if_pc + imm, mod 2^32.
- Class priority when multiple flags are set: if_cond_branch > if_jump > if_link; if_uncond_branch with neither jump nor link is treated as jump.
- Conditional branch: taken = counter[1]; target = if_pc + imm if taken, else if_pc + 4.
- JAL/JALR: a BTB hit (valid and tag equal) gives taken=1 with the BTB target. A miss gives taken=0 with target if_pc + 4.
- Non-branch with if_valid=1: taken=0, target if_pc + 4.
- if_valid=0: next-cycle pred_valid=0, pred_taken=0, pred_target=0.
- Update, when upd_valid=1:
  - upd_cond=1: the counter at the upd_pc index increments if taken, decrements otherwise, saturating at 2'b11 and 2'b00.
  - upd_taken=1 (any class): the BTB entry at the upd_pc index is written with valid=1, tag, and upd_target. A conflicting entry is replaced.
  - upd_taken=0 leaves the BTB unchanged.
- A same-cycle lookup and update to the same entry: the lookup sees the pre-update contents (read-before-write).

## Timing
- Prediction latency is 1 cycle. Fetch inputs sampled at edge N appear on pred_* after edge N. A new prediction is produced every cycle; there is no stall input.
- Update latency is 1 cycle. Table state written at edge N is visible to lookups sampled at edge N+1.
- Reset is asynchronous and immediate, including when asserted mid-operation:
  - pred_valid=0, pred_taken=0, pred_target=32'h0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - The first lookup after reset deassertion uses the reset tables.

## Test plan
- Reset, then a cond branch at pc=0x100 with imm1=7'h7F, imm2=5'h19 (imm=-8) -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- One update (pc=0x100, cond, taken) followed by the same lookup -> pred_taken=1, pred_target=0xF8. Three more taken updates keep the counter at 11. Then three not-taken updates -> predicts not-taken, counter 00.
- JAL at pc=0x200 with an empty BTB -> taken=0, target 0x204. After update (pc=0x200, taken, target 0x400) -> taken=1, target 0x400. A JAL at pc 0x200 + BTB_ENTRIES*4*2^TAG_BITS... use pc=0x240 (same idx, different tag) -> miss, taken=0, target 0x244.
- Same-cycle update (pc=0x300, cond, taken) and cond lookup at 0x300 from reset -> lookup predicts not-taken. The lookup on the following cycle predicts taken.
- Reset asserted between two edges while the BTB and BHT are trained -> outputs go to 0 immediately. The post-reset JAL lookup at 0x200 misses, and the cond lookup at 0x100 predicts not-taken.
- if_valid=0 with arbitrary other inputs -> pred_valid=0, pred_taken=0, pred_target=0. All four flags set on a cond encoding -> treated as conditional.
